// File: rtl/sm2_fast_reduction_seq.sv
// Sequential SM2 fast reduction: a 512-bit product is folded to a signed 258-bit value,
// then brought into range by an iterative add/subtract-p loop with a valid/ready handshake.
module sm2_fast_reduction_seq #(
    parameter int TAG_W       = 4,
    parameter int FOLD_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_data,
    input  logic             in_lazy,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_corr_cnt,
    output logic             busy
);

    localparam logic [255:0] P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] K = 256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

    typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, CORR, DONE} state_t;

    state_t             state_q, state_d;
    logic [511:0]       data_q, data_d;
    logic               lazy_q, lazy_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   outTag_q, outTag_d;
    logic [260:0]       tSum_q, tSum_d;
    logic [257:0]       rVal_q, rVal_d;
    logic [1:0]         corrCnt_q, corrCnt_d;
    logic [255:0]       outData_q, outData_d;

    logic [31:0]        c [16];
    logic [260:0]       posSum, negSum, tCalc, foldSrc;
    logic signed [257:0] hExt, hk, rCalc;
    logic               rNeg, needSub;

    function automatic logic [260:0] ext(input logic [255:0] v);
        return {5'd0, v};
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            c[i] = data_q[32*i +: 32];
        end
    end

    // T = sum of the word-permuted sets; kept exact in 261-bit two's complement.
    always_comb begin
        posSum = ext(data_q[255:0])
               + ext({c[15], c[14], c[13], c[12], c[11], 32'd0, c[9], c[8]})
               + (ext({c[14], 32'd0, c[15], c[14], c[13], 32'd0, c[14], c[13]}) << 1)
               + (ext({c[13], 160'd0, c[15], c[14]}) << 1)
               + (ext({c[12], 192'd0, c[15]}) << 1)
               + ext({c[11], c[11], c[10], c[15], c[14], 32'd0, c[13], c[12]})
               + ext({c[10], c[15], c[14], c[13], c[12], 32'd0, c[11], c[10]})
               + ext({c[9], 64'd0, c[9], c[8], 32'd0, c[10], c[9]})
               + ext({c[8], 96'd0, c[15], 32'd0, c[12], c[11]})
               + (ext({c[15], 224'd0}) << 1);
        negSum = ext({160'd0, c[14], 64'd0})
               + ext({160'd0, c[13], 64'd0})
               + ext({160'd0, c[9], 64'd0})
               + ext({160'd0, c[8], 64'd0});
        tCalc  = posSum - negSum;

        // With a single fold stage the second fold reads T directly instead of the register.
        foldSrc = (FOLD_STAGES == 1) ? tCalc : tSum_q;
        hExt    = {{253{foldSrc[260]}}, foldSrc[260:256]};
        hk      = hExt * $signed({2'b00, K});
        rCalc   = $signed({2'b00, foldSrc[255:0]}) + hk;
    end

    always_comb begin
        rNeg    = rVal_q[257];
        needSub = !rNeg && (lazy_q ? rVal_q[256] : (rVal_q[256:0] >= {1'b0, P}));
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        lazy_d    = lazy_q;
        tag_d     = tag_q;
        outTag_d  = outTag_q;
        tSum_d    = tSum_q;
        rVal_d    = rVal_q;
        corrCnt_d = corrCnt_q;
        outData_d = outData_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d    = in_data;
                    lazy_d    = in_lazy;
                    tag_d     = in_tag;
                    corrCnt_d = 2'd0;
                    state_d   = FOLD1;
                end
            end
            FOLD1: begin
                tSum_d = tCalc;
                if (FOLD_STAGES == 1) begin
                    rVal_d  = rCalc;
                    state_d = CORR;
                end else begin
                    state_d = FOLD2;
                end
            end
            FOLD2: begin
                rVal_d  = rCalc;
                state_d = CORR;
            end
            CORR: begin
                if (rNeg) begin
                    rVal_d    = rVal_q + {2'b00, P};
                    corrCnt_d = corrCnt_q + 2'd1;
                end else if (needSub) begin
                    rVal_d    = rVal_q - {2'b00, P};
                    corrCnt_d = corrCnt_q + 2'd1;
                end else begin
                    outData_d = rVal_q[255:0];
                    outTag_d  = tag_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            lazy_q    <= 1'b0;
            tag_q     <= '0;
            outTag_q  <= '0;
            tSum_q    <= '0;
            rVal_q    <= '0;
            corrCnt_q <= 2'd0;
            outData_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            lazy_q    <= lazy_d;
            tag_q     <= tag_d;
            outTag_q  <= outTag_d;
            tSum_q    <= tSum_d;
            rVal_q    <= rVal_d;
            corrCnt_q <= corrCnt_d;
            outData_q <= outData_d;
        end
    end

    assign in_ready     = (state_q == IDLE) && !rst;
    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_data     = outData_q;
    assign out_tag      = outTag_q;
    assign out_corr_cnt = corrCnt_q;

endmodule

// File: tb/tb_sm2_fast_reduction_seq.sv
// Scoreboard bench for sm2_fast_reduction_seq: two instances (two and one fold stages)
// are checked against a plain a mod p model, plus backpressure and mid-flight reset.
module tb_sm2_fast_reduction_seq;

    localparam logic [255:0] P   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] K   = 256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
    localparam logic [255:0] PM1 = P - 256'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         inValid0, inLazy0, outReady0, inReady0, outValid0, busy0;
    logic [511:0] inData0;
    logic [3:0]   inTag0, outTag0;
    logic [255:0] outData0;
    logic [1:0]   outCnt0;
    logic         inValid1, inLazy1, outReady1, inReady1, outValid1, busy1;
    logic [511:0] inData1;
    logic [3:0]   inTag1, outTag1;
    logic [255:0] outData1;
    logic [1:0]   outCnt1;

    sm2_fast_reduction_seq #(.TAG_W(4), .FOLD_STAGES(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0), .in_lazy(inLazy0), .in_tag(inTag0),
        .out_valid(outValid0), .out_ready(outReady0), .out_data(outData0), .out_tag(outTag0),
        .out_corr_cnt(outCnt0), .busy(busy0)
    );

    sm2_fast_reduction_seq #(.TAG_W(4), .FOLD_STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1), .in_lazy(inLazy1), .in_tag(inTag1),
        .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1), .out_tag(outTag1),
        .out_corr_cnt(outCnt1), .busy(busy1)
    );

    typedef struct {
        logic [255:0] modVal;
        logic         lazy;
        logic [3:0]   tag;
        logic         exactChk;
        logic [255:0] exactVal;
        logic         cntChk;
        logic [1:0]   cnt;
        int           acceptCycle;
    } exp_t;

    exp_t expQ0[$];
    exp_t expQ1[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCnt   = 0;
    int   firstValid0 = 0;
    int   firstValid1 = 0;
    bit   seen0 = 1'b0;
    bit   seen1 = 1'b0;
    bit   hold0 = 1'b0;
    bit   randBp = 1'b0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [255:0] modP(input logic [511:0] a);
        logic [511:0] r;
        r = a % {256'd0, P};
        return r[255:0];
    endfunction

    task automatic report(input string name, input logic [255:0] act, input logic [255:0] req, input bit ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic checkOutput(input int which, input logic [255:0] data, input logic [3:0] tag,
                               input logic [1:0] cnt, input int firstValid);
        exp_t e;
        int   fs;
        int   lat;
        if ((which == 0 && expQ0.size() == 0) || (which == 1 && expQ1.size() == 0)) begin
            report("unexpectedOutput", 256'(tag), 256'd0, 1'b0);
            return;
        end
        if (which == 0) e = expQ0.pop_front();
        else            e = expQ1.pop_front();
        fs  = (which == 0) ? 2 : 1;
        lat = firstValid - e.acceptCycle;
        report("tag", 256'(tag), 256'(e.tag), tag == e.tag);
        if (e.exactChk)
            report("dataExact", data, e.exactVal, data == e.exactVal);
        else if (e.lazy)
            report("dataLazyCongruent", modP({256'd0, data}), e.modVal, modP({256'd0, data}) == e.modVal);
        else
            report("dataFull", data, e.modVal, data == e.modVal);
        if (e.cntChk)
            report("corrCnt", 256'(cnt), 256'(e.cnt), cnt == e.cnt);
        report("latency", 256'(lat), 256'(fs + 2 + int'(cnt)), lat == fs + 2 + int'(cnt));
        report("corrIterBound", 256'(lat), 256'(fs + 5), lat <= fs + 5);
    endtask

    // Backpressure source: free-running ready, random stalls, or a forced hold on the first instance.
    always @(posedge clk) begin
        #1;
        outReady0 = hold0 ? 1'b0 : (randBp ? ($urandom_range(0, 3) != 0) : 1'b1);
        outReady1 = randBp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitors pop the scoreboard on every output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            seen0 = 1'b0;
        end else if (outValid0) begin
            if (!seen0) begin
                seen0 = 1'b1;
                firstValid0 = cycleCnt;
            end
            if (outReady0) begin
                checkOutput(0, outData0, outTag0, outCnt0, firstValid0);
                seen0 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            seen1 = 1'b0;
        end else if (outValid1) begin
            if (!seen1) begin
                seen1 = 1'b1;
                firstValid1 = cycleCnt;
            end
            if (outReady1) begin
                checkOutput(1, outData1, outTag1, outCnt1, firstValid1);
                seen1 = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int which, input logic [511:0] a, input logic lazy, input logic [3:0] tag,
                                 input bit track, input bit exactChk, input logic [255:0] exactVal,
                                 input bit cntChk, input logic [1:0] cnt);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (((which == 0) ? inReady0 : inReady1) && !rst) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            report("inReadyTimeout", 256'd0, 256'd1, 1'b0);
            return;
        end
        if (which == 0) begin
            inData0 = a; inLazy0 = lazy; inTag0 = tag; inValid0 = 1'b1;
        end else begin
            inData1 = a; inLazy1 = lazy; inTag1 = tag; inValid1 = 1'b1;
        end
        e.modVal      = modP(a);
        e.lazy        = lazy;
        e.tag         = tag;
        e.exactChk    = exactChk;
        e.exactVal    = exactVal;
        e.cntChk      = cntChk;
        e.cnt         = cnt;
        e.acceptCycle = cycleCnt;
        if (track) begin
            if (which == 0) expQ0.push_back(e);
            else            expQ1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (which == 0) inValid0 = 1'b0;
        else            inValid1 = 1'b0;
    endtask

    task automatic waitDrain(input int which);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (which == 0 && expQ0.size() == 0 && !busy0) begin done = 1'b1; break; end
            if (which == 1 && expQ1.size() == 0 && !busy1) begin done = 1'b1; break; end
        end
        if (!done) report("drainTimeout", 256'd0, 256'd1, 1'b0);
    endtask

    task automatic runDirected(input int which);
        logic [511:0] pow256;
        logic [511:0] allOnes;
        logic [511:0] sq;
        pow256  = 512'd1 << 256;
        allOnes = '1;
        sq      = {256'd0, PM1} * {256'd0, PM1};
        applyStimulus(which, 512'd0, 1'b0, 4'd1, 1'b1, 1'b1, 256'd0, 1'b1, 2'd0);
        applyStimulus(which, {256'd0, PM1}, 1'b0, 4'd2, 1'b1, 1'b1, PM1, 1'b1, 2'd0);
        applyStimulus(which, {256'd0, P}, 1'b0, 4'd3, 1'b1, 1'b1, 256'd0, 1'b1, 2'd1);
        applyStimulus(which, {256'd0, P}, 1'b1, 4'd4, 1'b1, 1'b1, P, 1'b1, 2'd0);
        applyStimulus(which, pow256, 1'b0, 4'd7, 1'b1, 1'b1, K, 1'b1, 2'd0);
        applyStimulus(which, allOnes, 1'b0, 4'd8, 1'b1, 1'b0, 256'd0, 1'b0, 2'd0);
        applyStimulus(which, allOnes, 1'b1, 4'd9, 1'b1, 1'b0, 256'd0, 1'b0, 2'd0);
        applyStimulus(which, sq, 1'b0, 4'd10, 1'b1, 1'b0, 256'd0, 1'b0, 2'd0);
        applyStimulus(which, sq, 1'b1, 4'd11, 1'b1, 1'b0, 256'd0, 1'b0, 2'd0);
        waitDrain(which);
    endtask

    task automatic randomRun(input int which, input int n);
        logic [511:0] a;
        logic [3:0]   tag;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 16; k++) a[k*32 +: 32] = $urandom();
            if ($urandom_range(0, 3) == 0) a[511:256] = '1;
            tag = 4'($urandom_range(0, 15));
            if (tag == 4'h5) tag = 4'hC;
            applyStimulus(which, a, 1'($urandom_range(0, 1)), tag, 1'b1, 1'b0, 256'd0, 1'b0, 2'd0);
        end
        waitDrain(which);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] a;
        bit           got;
        rst = 1'b1;
        inValid0 = 1'b0; inLazy0 = 1'b0; inData0 = '0; inTag0 = '0; outReady0 = 1'b1;
        inValid1 = 1'b0; inLazy1 = 1'b0; inData1 = '0; inTag1 = '0; outReady1 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        report("resetInReadyLow", 256'(inReady0), 256'd0, inReady0 == 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        report("resetInReady", 256'(inReady0), 256'd1, inReady0 == 1'b1);
        report("resetOutValid", 256'(outValid0), 256'd0, outValid0 == 1'b0);
        report("resetOutData", outData0, 256'd0, outData0 == 256'd0);
        report("resetOutTag", 256'(outTag0), 256'd0, outTag0 == 4'd0);
        report("resetCorrCnt", 256'(outCnt0), 256'd0, outCnt0 == 2'd0);
        report("resetBusy", 256'(busy0), 256'd0, busy0 == 1'b0);

        runDirected(0);
        runDirected(1);

        randBp = 1'b1;
        randomRun(0, 40);
        randomRun(1, 15);
        randBp = 1'b0;
        repeat (2) @(negedge clk);

        // Stalled consumer: result and tag must hold, and no new request may slip in.
        hold0 = 1'b1;
        applyStimulus(0, {256'd0, P}, 1'b0, 4'hA, 1'b1, 1'b1, 256'd0, 1'b1, 2'd1);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (outValid0) begin got = 1'b1; break; end
        end
        if (!got) report("bpValidTimeout", 256'd0, 256'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            report("bpValid", 256'(outValid0), 256'd1, outValid0 == 1'b1);
            report("bpData", outData0, 256'd0, outData0 == 256'd0);
            report("bpTag", 256'(outTag0), 256'hA, outTag0 == 4'hA);
            report("bpCnt", 256'(outCnt0), 256'd1, outCnt0 == 2'd1);
            report("bpInReady", 256'(inReady0), 256'd0, inReady0 == 1'b0);
            inData0 = {16{32'h1234_5678}}; inTag0 = 4'h3; inLazy0 = 1'b0; inValid0 = 1'b1;
        end
        inValid0 = 1'b0;
        hold0 = 1'b0;
        @(negedge clk);
        report("bpInReadyHold", 256'(inReady0), 256'd0, inReady0 == 1'b0);
        @(negedge clk);
        report("bpInReadyRise", 256'(inReady0), 256'd1, inReady0 == 1'b1);
        report("bpValidDrop", 256'(outValid0), 256'd0, outValid0 == 1'b0);
        waitDrain(0);

        // Reset while the second fold is in progress; the dropped tag 5 must never surface.
        for (int k = 0; k < 16; k++) a[k*32 +: 32] = $urandom();
        applyStimulus(0, a, 1'b0, 4'h5, 1'b0, 1'b0, 256'd0, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        report("rstBusy", 256'(busy0), 256'd0, busy0 == 1'b0);
        report("rstOutValid", 256'(outValid0), 256'd0, outValid0 == 1'b0);
        report("rstInReady", 256'(inReady0), 256'd1, inReady0 == 1'b1);
        applyStimulus(0, {255'd0, P, 1'b0}, 1'b0, 4'h6, 1'b1, 1'b1, 256'd0, 1'b1, 2'd1);
        waitDrain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sm2_fast_reduction_seq.md
Name: sm2_fast_reduction_seq

Overview:
- Sequential, handshaked successor to the combinational SM2 fast-reduction block.
- Reduces a 512-bit product modulo SM2 p = FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF.
- Folding is registered, and the final correction is an iterative add/sub-p loop instead of parallel add/sub candidates.
- Adds a lazy mode, tag pass-through, backpressure, and a correction-count status. It sits between the multiplier and the point-arithmetic FSMs.

Parameters:
- TAG_W, 4, width of the opaque transaction tag carried from input to output.
- FOLD_STAGES, 2. Legal values 1 or 2. With 2, FOLD1 and FOLD2 take one cycle each. With 1, both folds complete in a single cycle.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  512  operand a, unsigned; 32-bit words c15..c0.
- in_lazy  input  1  1: output only needs to be < 2^256 and congruent to a mod p.
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  256  result.
- out_tag  output  TAG_W  tag of this result.
- out_corr_cnt  output  2  number of CORR iterations used (0..3).
- busy  output  1  state != IDLE.

Behaviour:
- Reset: synchronous, active-high. Applies to the single clock clk.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_tag=0, out_corr_cnt=0, busy=0.
  - An in-flight transaction is dropped with no output. Reset overrides a same-cycle accept.
- One transaction in flight. in_ready = (state==IDLE) && !rst.
- Accept occurs when in_valid && in_ready. On accept, in_data, in_lazy and in_tag are registered.
- States: IDLE -> FOLD1 -> FOLD2 -> CORR -> DONE -> IDLE. When FOLD_STAGES=1, FOLD2 is skipped.
- FOLD1: compute signed T (261-bit, two's complement):
  - T = s1+s2+2s3+2s4+2s5+s6+s7+s8+s9+2s10 - s11 - s12 - s13 - s14.
  - Word layouts are the standard SM2 fast-reduction sets:
    - s1 = {c7..c0}
    - s2 = {c15,c14,c13,c12,c11,0,c9,c8}
    - s3 = {c14,0,c15,c14,c13,0,c14,c13}
    - s4 = {c13,0,0,0,0,0,c15,c14}
    - s5 = {c12,0,0,0,0,0,0,c15}
    - s6 = {c11,c11,c10,c15,c14,0,c13,c12}
    - s7 = {c10,c15,c14,c13,c12,0,c11,c10}
    - s8 = {c9,0,0,c9,c8,0,c10,c9}
    - s9 = {c8,0,0,0,c15,0,c12,c11}
    - s10 = {c15,0,0,0,0,0,0,0}
    - s11..s14 carry c14, c13, c9, c8 respectively in word 2 only.
  - Bound: -2^98 < T < 14*2^256.
- FOLD2: split T = H*2^256 + L, with L unsigned 256-bit and H signed 5-bit.
  - R = L + H*K, where K = 2^256 - p = 00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001.
  - R is held as signed 258-bit. Invariant: -p < R < 2^257.
- CORR: one add or subtract per cycle; out_corr_cnt increments per iteration.
  - Full mode (lazy=0): if R<0, R+=p; else if R>=p, R-=p; else go to DONE.
  - Lazy mode (lazy=1): if R<0, R+=p; else if R>=2^256, R-=p; else go to DONE.
  - CORR takes at most 3 iterations. A 4th iteration is a design error and is flagged by a bench assertion.
  - The exit test that finds no correction needed consumes its own cycle.
- Latency: accept at cycle t gives out_valid at t + FOLD_STAGES + 1 + out_corr_cnt + 1.
- DONE:
  - out_valid=1. out_data, out_tag and out_corr_cnt are stable while out_valid && !out_ready.
  - On out_ready, out_valid drops next cycle and the state returns to IDLE.
  - in_ready rises the cycle after the handshake. There is no same-cycle accept/complete overlap.
- Arithmetic: all intermediates are sized to bounds, with no truncation before DONE. out_data = R[255:0] with R in [0,p) (full) or [0,2^256) (lazy).

Test Plan:
- Zero and identity:
  - a=0, lazy=0 -> out_data=0, out_corr_cnt=0.
  - a=p-1 -> out_data=p-1, out_corr_cnt=0.
  - Check latency = FOLD_STAGES+2 cycles for both parameter values.
- Equal to modulus:
  - a=p, lazy=0 -> out_data=0, out_corr_cnt=1.
  - a=p, lazy=1 -> out_data=p, out_corr_cnt=0.
- Power of two: a=2^256 (c8=1, rest 0) -> out_data=00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001.
- Maximum input:
  - a=2^512-1 and a=(p-1)^2, both modes.
  - out_data must match the bench golden a mod p in full mode.
  - In lazy mode, out_data must be ≡ the same value and < 2^256.
  - out_corr_cnt <= 3.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid with tag=4'hA.
  - out_data, out_tag and out_corr_cnt stay stable. in_ready=0 throughout, and a request with in_valid=1 is not accepted.
  - Release out_ready: in_ready=1 one cycle later.
- Reset mid-operation:
  - Assert rst during FOLD2 or CORR -> next cycle busy=0, out_valid=0, in_ready=1.
  - The dropped tag never appears.
  - A following request (a=2p) returns out_data=0.
